// File: rtl/io_channel_scheduler.sv
// rtl/io_channel_scheduler.sv - shares the input FIFO and output ring between two requesters
// Round-robin arbitration per channel; each acknowledge is registered and lasts one cycle.
module io_channel_scheduler #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn  = 16,
    parameter int NOut = 16,
    localparam int CW  = $clog2(NIn + 1),
    localparam int OW  = $clog2(NOut + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load_valid,
    input  logic [MemoryElementWidth-1:0] load_data,
    output logic                          load_ready,
    input  logic [1:0]                    in_req,
    output logic [1:0]                    in_ack,
    output logic [MemoryElementWidth-1:0] in_data,
    output logic                          in_empty,
    output logic [CW-1:0]                 in_size,
    input  logic [1:0]                    out_req,
    input  logic [MemoryElementWidth-1:0] out_data0,
    input  logic [MemoryElementWidth-1:0] out_data1,
    output logic [1:0]                    out_ack,
    input  logic                          drain_req,
    output logic                          drain_valid,
    output logic [MemoryElementWidth-1:0] drain_data,
    output logic [OW-1:0]                 out_count
);
    localparam int IPW = (NIn  > 1) ? $clog2(NIn)  : 1;
    localparam int OPW = (NOut > 1) ? $clog2(NOut) : 1;
    localparam logic [CW-1:0]  InFull   = CW'(NIn);
    localparam logic [OW-1:0]  OutFull  = OW'(NOut);
    localparam logic [IPW-1:0] InLast   = IPW'(NIn - 1);
    localparam logic [OPW-1:0] OutLast  = OPW'(NOut - 1);

    logic [MemoryElementWidth-1:0] r_in_mem  [NIn];
    logic [MemoryElementWidth-1:0] r_out_mem [NOut];
    logic [IPW-1:0] r_in_rd, r_in_wr;
    logic [OPW-1:0] r_out_rd, r_out_wr;
    logic [CW-1:0]  r_in_count;
    logic [OW-1:0]  r_out_count;
    logic           r_in_ptr, r_out_ptr;
    logic [1:0]     r_in_ack, r_out_ack;
    logic [MemoryElementWidth-1:0] r_in_data, r_drain_data;
    logic           r_in_empty, r_drain_valid;

    logic [1:0] w_in_gnt, w_out_gnt;
    logic       w_in_any, w_pop, w_load, w_push, w_drain;
    logic [MemoryElementWidth-1:0] w_push_data;

    // Single eligible requester wins outright; a tie goes to the pointer.
    function automatic logic [1:0] rr_grant(input logic [1:0] elig, input logic ptr);
        case (elig)
            2'b01:   rr_grant = 2'b01;
            2'b10:   rr_grant = 2'b10;
            2'b11:   rr_grant = ptr ? 2'b10 : 2'b01;
            default: rr_grant = 2'b00;
        endcase
    endfunction

    always_comb begin
        w_in_gnt    = rr_grant(in_req & ~r_in_ack, r_in_ptr);
        w_in_any    = |w_in_gnt;
        w_pop       = w_in_any && (r_in_count != '0);
        w_load      = load_valid && (r_in_count != InFull);
        w_out_gnt   = (r_out_count != OutFull) ? rr_grant(out_req & ~r_out_ack, r_out_ptr) : 2'b00;
        w_push      = |w_out_gnt;
        w_push_data = w_out_gnt[1] ? out_data1 : out_data0;
        w_drain     = drain_req && (r_out_count != '0);
    end

    always_ff @(posedge clock) begin
        if (w_load) r_in_mem[r_in_wr] <= load_data;
        if (w_push) r_out_mem[r_out_wr] <= w_push_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_rd       <= '0;
            r_in_wr       <= '0;
            r_in_count    <= '0;
            r_in_ptr      <= 1'b0;
            r_in_ack      <= 2'b00;
            r_in_data     <= '0;
            r_in_empty    <= 1'b0;
            r_out_rd      <= '0;
            r_out_wr      <= '0;
            r_out_count   <= '0;
            r_out_ptr     <= 1'b0;
            r_out_ack     <= 2'b00;
            r_drain_valid <= 1'b0;
            r_drain_data  <= '0;
        end else begin
            if (w_load) r_in_wr <= (r_in_wr == InLast) ? '0 : r_in_wr + 1'b1;
            if (w_pop)  r_in_rd <= (r_in_rd == InLast) ? '0 : r_in_rd + 1'b1;
            r_in_count <= r_in_count + CW'(w_load) - CW'(w_pop);
            if (w_in_any) r_in_ptr <= w_in_gnt[0];
            r_in_ack   <= w_in_gnt;
            r_in_data  <= w_pop ? r_in_mem[r_in_rd] : '0;
            r_in_empty <= w_in_any && !w_pop;

            if (w_push)  r_out_wr <= (r_out_wr == OutLast) ? '0 : r_out_wr + 1'b1;
            if (w_drain) r_out_rd <= (r_out_rd == OutLast) ? '0 : r_out_rd + 1'b1;
            r_out_count <= r_out_count + OW'(w_push) - OW'(w_drain);
            if (w_push) r_out_ptr <= w_out_gnt[0];
            r_out_ack     <= w_out_gnt;
            r_drain_valid <= w_drain;
            r_drain_data  <= w_drain ? r_out_mem[r_out_rd] : '0;
        end
    end

    assign load_ready  = (r_in_count != InFull);
    assign in_ack      = r_in_ack;
    assign in_data     = r_in_data;
    assign in_empty    = r_in_empty;
    assign in_size     = r_in_count;
    assign out_ack     = r_out_ack;
    assign drain_valid = r_drain_valid;
    assign drain_data  = r_drain_data;
    assign out_count   = r_out_count;
endmodule

// File: tb/tb_io_channel_scheduler.sv
// tb/tb_io_channel_scheduler.sv - scoreboard bench for io_channel_scheduler
// Expected acks/words are queued at stimulus time and popped by the output monitor.
module tb_io_channel_scheduler;
    localparam int W = 12;
    localparam int NIn = 16;
    localparam int NOut = 16;
    localparam int CW = $clog2(NIn + 1);
    localparam int OW = $clog2(NOut + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0;
    logic [W-1:0]  load_data = '0;
    logic          load_ready;
    logic [1:0]    in_req = 2'b00;
    logic [1:0]    in_ack;
    logic [W-1:0]  in_data;
    logic          in_empty;
    logic [CW-1:0] in_size;
    logic [1:0]    out_req = 2'b00;
    logic [W-1:0]  out_data0 = '0;
    logic [W-1:0]  out_data1 = '0;
    logic [1:0]    out_ack;
    logic          drain_req = 1'b0;
    logic          drain_valid;
    logic [W-1:0]  drain_data;
    logic [OW-1:0] out_count;

    io_channel_scheduler #(.MemoryElementWidth(W), .NIn(NIn), .NOut(NOut)) dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .in_req(in_req), .in_ack(in_ack), .in_data(in_data), .in_empty(in_empty), .in_size(in_size),
        .out_req(out_req), .out_data0(out_data0), .out_data1(out_data1), .out_ack(out_ack),
        .drain_req(drain_req), .drain_valid(drain_valid), .drain_data(drain_data), .out_count(out_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]   ack;
        logic [W-1:0] data;
        logic         empty;
    } in_exp_t;

    in_exp_t      exp_in[$];
    logic [W-1:0] exp_drain[$];
    logic [1:0]   exp_oack[$];
    int passed = 0;
    int total = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    always begin
        @(posedge clock);
        #1;
        if (in_ack != 2'b00) begin
            if (exp_in.size() == 0) check("in_ack_unexpected", {30'd0, in_ack}, 0);
            else begin
                in_exp_t e;
                e = exp_in.pop_front();
                check("in_ack", {30'd0, in_ack}, {30'd0, e.ack});
                check("in_data", {20'd0, in_data}, {20'd0, e.data});
                check("in_empty", {31'd0, in_empty}, {31'd0, e.empty});
            end
        end
        if (out_ack != 2'b00) begin
            if (exp_oack.size() == 0) check("out_ack_unexpected", {30'd0, out_ack}, 0);
            else check("out_ack", {30'd0, out_ack}, {30'd0, exp_oack.pop_front()});
        end
        if (drain_valid) begin
            if (exp_drain.size() == 0) check("drain_unexpected", {20'd0, drain_data}, 0);
            else check("drain_data", {20'd0, drain_data}, {20'd0, exp_drain.pop_front()});
        end
    end

    task automatic load(input logic [W-1:0] d);
        load_valid = 1'b1;
        load_data  = d;
        step();
        load_valid = 1'b0;
    endtask

    task automatic do_in(input int r, input logic [W-1:0] d, input logic empty);
        in_exp_t e;
        int g;
        e.ack = (r == 1) ? 2'b10 : 2'b01;
        e.data = d;
        e.empty = empty;
        exp_in.push_back(e);
        in_req[r] = 1'b1;
        g = 0;
        do begin
            step();
            g++;
        end while (!in_ack[r] && g < 20);
        if (!in_ack[r]) check("in_timeout", 0, 1);
        in_req[r] = 1'b0;
    endtask

    task automatic do_out(input int r, input logic [W-1:0] d);
        int g;
        exp_oack.push_back((r == 1) ? 2'b10 : 2'b01);
        if (r == 1) out_data1 = d; else out_data0 = d;
        out_req[r] = 1'b1;
        g = 0;
        do begin
            step();
            g++;
        end while (!out_ack[r] && g < 20);
        if (!out_ack[r]) check("out_timeout", 0, 1);
        out_req[r] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ack"}, {30'd0, in_ack}, 0);
        check({tag, "_out_ack"}, {30'd0, out_ack}, 0);
        check({tag, "_drain_valid"}, {31'd0, drain_valid}, 0);
        check({tag, "_in_empty"}, {31'd0, in_empty}, 0);
        check({tag, "_in_data"}, {20'd0, in_data}, 0);
        check({tag, "_drain_data"}, {20'd0, drain_data}, 0);
        check({tag, "_in_size"}, {27'd0, in_size}, 0);
        check({tag, "_out_count"}, {27'd0, out_count}, 0);
        check({tag, "_load_ready"}, {31'd0, load_ready}, 1);
    endtask

    initial begin
        int n;
        int g;
        #1;
        check_reset_outputs("por");
        step();
        reset = 1'b0;
        step();

        // load and read
        load(12'd88);
        load(12'd44);
        check("ld_size2", {27'd0, in_size}, 2);
        do_in(0, 12'd88, 1'b0);
        check("rd_size1", {27'd0, in_size}, 1);
        do_in(1, 12'd44, 1'b0);
        check("rd_size0", {27'd0, in_size}, 0);
        do_in(0, 12'd0, 1'b1);

        // contention on the output channel
        out_data0 = 12'd7;
        out_data1 = 12'd9;
        for (int i = 0; i < 2; i++) begin
            exp_oack.push_back(2'b01);
            exp_oack.push_back(2'b10);
            exp_drain.push_back(12'd7);
            exp_drain.push_back(12'd9);
        end
        out_req = 2'b11;
        n = 0;
        g = 0;
        while (n < 4 && g < 20) begin
            step();
            g++;
            if (out_ack != 2'b00) n++;
        end
        if (n < 4) check("contend_timeout", n, 4);
        out_req = 2'b00;
        check("contend_count", {27'd0, out_count}, 4);
        drain_req = 1'b1;
        repeat (4) step();
        drain_req = 1'b0;
        step();
        check("contend_drained", {27'd0, out_count}, 0);

        // output ring full
        for (int i = 0; i < NOut; i++) begin
            exp_drain.push_back(W'(100 + i));
            do_out(0, W'(100 + i));
        end
        step();
        check("full_count", {27'd0, out_count}, NOut);
        out_data1 = 12'd200;
        out_req[1] = 1'b1;
        repeat (3) step();
        check("full_blocked", {30'd0, out_ack}, 0);
        exp_oack.push_back(2'b10);
        exp_drain.push_back(12'd200);
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        check("full_drain_noack", {30'd0, out_ack}, 0);
        step();
        check("full_late_ack", {30'd0, out_ack}, 2'b10);
        out_req[1] = 1'b0;
        drain_req = 1'b1;
        repeat (NOut) step();
        drain_req = 1'b0;
        step();
        check("full_empty", {27'd0, out_count}, 0);

        // input wrap-around
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < NIn; i++) load(W'(rnd * 16 + i + 1));
            check("wrap_full", {27'd0, in_size}, NIn);
            check("wrap_not_ready", {31'd0, load_ready}, 0);
            for (int i = 0; i < NIn; i++) do_in(i % 2, W'(rnd * 16 + i + 1), 1'b0);
            check("wrap_empty", {27'd0, in_size}, 0);
        end

        // simultaneous load and pop, then overflow
        load(12'd5);
        check("sim_size1", {27'd0, in_size}, 1);
        exp_in.push_back('{ack: 2'b01, data: 12'd5, empty: 1'b0});
        load_valid = 1'b1;
        load_data = 12'd6;
        in_req[0] = 1'b1;
        step();
        load_valid = 1'b0;
        in_req[0] = 1'b0;
        check("sim_ack", {30'd0, in_ack}, 2'b01);
        check("sim_size_kept", {27'd0, in_size}, 1);
        for (int i = 7; i < 22; i++) load(W'(i));
        check("ovf_full", {27'd0, in_size}, NIn);
        check("ovf_not_ready", {31'd0, load_ready}, 0);
        load(12'd99);
        check("ovf_dropped", {27'd0, in_size}, NIn);
        for (int i = 6; i < 22; i++) do_in(i % 2, W'(i), 1'b0);

        // reset mid-operation
        load(12'd1);
        load(12'd2);
        load(12'd3);
        do_out(0, 12'd50);
        in_req[0] = 1'b1;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        step();
        step();
        in_req[0] = 1'b0;
        reset = 1'b0;
        repeat (3) step();
        check("post_rst_in_ack", {30'd0, in_ack}, 0);
        check("post_rst_size", {27'd0, in_size}, 0);
        check("post_rst_count", {27'd0, out_count}, 0);
        do_in(0, 12'd0, 1'b1);

        repeat (3) step();
        check("left_in", exp_in.size(), 0);
        check("left_oack", exp_oack.size(), 0);
        check("left_drain", exp_drain.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/io_channel_scheduler.md
# io_channel_scheduler

Shares the machine's input and output channels between two instruction-execution requesters. It buffers loaded input words, serves `in` and `inSize` requests, and collects `out` words into a ring buffer that the test harness drains. Both channels use round-robin arbitration with a one-cycle registered acknowledge. It sits between the program sequencers and the `inMem`/`outMem` storage that the fpga test modules currently own.

## Interface
- `MemoryElementWidth`, 12: data word width W.
- `NIn`, 16: input buffer depth, in words.
- `NOut`, 16: output ring depth, in words.
- CW = $clog2(NIn+1) and OW = $clog2(NOut+1): count widths.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `load_valid`  in  1  harness pushes a word into the input buffer.
- `load_data`  in  W  word to load.
- `load_ready`  out  1  high when the input buffer is not full.
- `in_req`  in  2  per-requester `in` request.
- `in_ack`  out  2  one-hot, one-cycle acknowledge.
- `in_data`  out  W  word returned with `in_ack`.
- `in_empty`  out  1  valid with `in_ack`; the read found no word.
- `in_size`  out  CW  unread input words (the `inSize` value).
- `out_req`  in  2  per-requester `out` request.
- `out_data0`, `out_data1`  in  W  words offered by requesters 0 and 1.
- `out_ack`  out  2  one-hot, one-cycle acknowledge.
- `drain_req`  in  1  harness pops the oldest output word.
- `drain_valid`  out  1  one-cycle strobe for `drain_data`.
- `drain_data`  out  W  oldest output word.
- `out_count`  out  OW  words held in the output ring.

## Operation
- Input buffer is a FIFO with read pointer, write pointer and count registers. `in_size` = count.
- Load is accepted when `load_valid` && count < NIn. A load while full is dropped; `load_ready` = count < NIn.
- In-arbiter:
  - A requester is eligible when `in_req[r]` && !`in_ack[r]`.
  - If one requester is eligible, it is granted. If both are eligible, the requester named by `in_ptr` is granted.
  - After any grant, `in_ptr` moves to the other requester.
- Granted `in` with count > 0: pop the head word; next cycle `in_ack[r]`=1, `in_data`=word, `in_empty`=0.
- Granted `in` with count == 0: no pop; next cycle `in_ack[r]`=1, `in_data`=0, `in_empty`=1. This matches the program semantics that `in` on an exhausted channel leaves its target unchanged and advances.
- Out-arbiter uses the same eligibility and round-robin rules with its own `out_ptr`. A grant happens only when `out_count` < NOut, using the registered count. Granted data is written at the write pointer, and `out_ack[r]` pulses next cycle.
- Drain is performed when `drain_req` && `out_count` > 0. Next cycle `drain_valid`=1 and `drain_data`=head word. A drain while empty gives `drain_valid`=0.
- Pointers wrap modulo NIn or NOut; both depths may be non-powers of two.
- Simultaneous events:
  - Load and pop in the same cycle: both occur and the count is unchanged. A load into an empty buffer is not visible to a pop in the same cycle.
  - Push and drain in the same cycle: both occur. A full ring blocks the push even if a drain happens in that cycle.

## Timing
- Reset values, applied immediately: all counts and pointers 0; `in_ptr` = `out_ptr` = 0; `in_ack`, `out_ack`, `drain_valid`, `in_empty` = 0; `in_data`, `drain_data` = 0; `load_ready` = 1.
- Request to acknowledge latency is 1 cycle when uncontended. A loser waits at least 1 extra cycle.
- Requesters hold `req` and their data stable until ack, then drop `req` in the cycle after ack. `req` seen during the ack cycle is ignored.
- Each channel makes at most one grant per cycle. The in and out channels operate independently and concurrently.
- `in_size` and `out_count` reflect the state one cycle after the causing edge.
- Reset asserted mid-transaction aborts it. No ack is issued for the aborted transaction, and buffered words are discarded.

## Test plan
- **Load and read:** load 88, then 44. Expect `in_size`=2. Requester 0 `in` → ack with 88, `in_size`=1. Requester 1 `in` → ack with 44, `in_size`=0. Requester 0 `in` again → `in_empty`=1, `in_data`=0.
- **Contention:** both requesters assert `out_req` continuously with data 7 and 9. Expect acks alternating 0,1,0,1. Drain order is 7,9,7,9.
- **Output full:** push NOut words with no drain. Expect `out_count`=NOut and the next request not acked. Drain one word, then expect the pending push acked 2 cycles later.
- **Wrap-around:** three rounds of NIn loads and pops. Data is returned in FIFO order across the pointer wrap.
- **Simultaneous load, pop and overflow:** load and pop in the same cycle at count 1 → count stays 1. Load at count NIn → dropped, `load_ready`=0.
- **Reset mid-operation:** assert `reset` with `in_req` pending and buffers partly full. Expect all outputs at their reset values immediately and no ack after release until a new request.
